// File: rtl/spk_out_buf_if.sv
// Router-side spike packet channel: valid/ready handshake carrying a {z,y,x} ID.
interface spk_out_buf_if #(
    parameter int SW = 24
);
    logic          spk_out_vld;
    logic [SW-1:0] spk_out_data;
    logic          spk_out_rdy;

    modport master (output spk_out_vld, output spk_out_data, input spk_out_rdy);
    modport slave  (input spk_out_vld, input spk_out_data, output spk_out_rdy);
endinterface

// File: rtl/spk_out_buf.sv
// Spike output stage: buffers IDs of firing neurons, streams them to the router,
// back-pressures the controller and reports per-timestep count/done/overflow.
module spk_out_buf #(
    parameter int SW        = 24,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int AF_MARGIN = 4,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          soma_spk_vld,
    input  logic          soma_spk,
    input  logic [SW-1:0] config_spk_out_neuid,
    input  logic          work_config_busy,
    input  logic          config_clear,
    output logic          spk_out_config_full,
    output logic          spk_out_done,
    output logic [CW-1:0] spk_cnt,
    output logic          spk_ovf,
    spk_out_buf_if.master spk_out
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_RUN   = 2'd1;
    localparam logic [1:0]  ST_DRAIN = 2'd2;
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LVL_C = (AW+1)'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] CNT_MAX_C = {CW{1'b1}};

    logic [SW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic          out_vld_q, out_vld_d;
    logic [SW-1:0] out_data_q, out_data_d;
    logic          full_q, full_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    state_q, state_d;
    logic          push_s, pop_s, accept_s, empty_s;

    // Push/pop decisions and FIFO/output-register next state
    always_comb begin
        push_s     = soma_spk_vld & soma_spk;
        empty_s    = (occ_q == '0);
        pop_s      = ~empty_s & (~out_vld_q | spk_out.spk_out_rdy);
        // A full FIFO still takes a spike when an entry leaves in the same cycle
        accept_s   = push_s & ((occ_q != DEPTH_C) | pop_s);
        wr_ptr_d   = accept_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d   = pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        ovf_d      = ovf_q | (push_s & ~accept_s);
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        case ({accept_s, pop_s})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
        endcase
        if (pop_s) begin
            out_vld_d  = 1'b1;
            out_data_d = mem_q[rd_ptr_q];
        end else if (spk_out.spk_out_rdy) begin
            out_vld_d  = 1'b0;
        end else begin
            out_vld_d  = out_vld_q;
        end
        full_d = (occ_d >= AF_LVL_C);
    end

    // Timestep FSM, done pulse and saturating spike counter
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (accept_s && (cnt_q != CNT_MAX_C)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (work_config_busy) begin
                    state_d = ST_RUN;
                    cnt_d   = accept_s ? CW'(1) : '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!work_config_busy) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (work_config_busy) begin
                    state_d = ST_RUN;
                end else if (empty_s && !out_vld_q && !push_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers; clear behaves exactly like reset
    always_ff @(posedge clk) begin
        if (!rst_n || config_clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            full_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            state_q    <= ST_IDLE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            full_q     <= full_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset
    always_ff @(posedge clk) begin
        if (rst_n && !config_clear && accept_s) begin
            mem_q[wr_ptr_q] <= config_spk_out_neuid;
        end
    end

    assign spk_out.spk_out_vld  = out_vld_q;
    assign spk_out.spk_out_data = out_data_q;
    assign spk_out_config_full  = full_q;
    assign spk_out_done         = done_q;
    assign spk_cnt              = cnt_q;
    assign spk_ovf              = ovf_q;

endmodule

// File: tb/tb_spk_out_buf.sv
// Randomized self-checking bench for spk_out_buf against a queue-based reference model.
module tb_spk_out_buf;
    localparam int SW = 24;
    localparam int CW = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_vld = 1'b0, s_spk = 1'b0, busy = 1'b0, clr = 1'b0;
    logic [SW-1:0] id = '0;
    logic          spk_out_config_full, spk_out_done, spk_ovf;
    logic [CW-1:0] spk_cnt;

    spk_out_buf_if #(.SW(SW)) bus ();

    spk_out_buf #(.SW(SW), .DEPTH(16), .AW(4), .AF_MARGIN(4), .CW(CW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .soma_spk_vld         (s_vld),
        .soma_spk             (s_spk),
        .config_spk_out_neuid (id),
        .work_config_busy     (busy),
        .config_clear         (clr),
        .spk_out_config_full  (spk_out_config_full),
        .spk_out_done         (spk_out_done),
        .spk_cnt              (spk_cnt),
        .spk_ovf              (spk_ovf),
        .spk_out              (bus.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: the FIFO is a queue, the timestep phase is 0/1/2 = idle/run/drain
    logic [SW-1:0] m_q [$];
    logic          m_vld = 1'b0, m_full = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
    logic [SW-1:0] m_data = '0;
    int            m_cnt = 0, m_phase = 0;

    logic [SW-1:0] hs_log [$];
    int            done_cnt = 0;

    function automatic logic [SW+CW+3:0] dut_v();
        return {bus.spk_out_vld, bus.spk_out_data, spk_out_config_full, spk_out_done, spk_ovf, spk_cnt};
    endfunction

    function automatic logic [SW+CW+3:0] mdl_v();
        return {m_vld, m_data, m_full, m_done, m_ovf, CW'(m_cnt)};
    endfunction

    task automatic tick();
        bit push, pop, acc;
        int sz;
        sz   = m_q.size();
        push = s_vld && s_spk;
        pop  = (sz > 0) && (!m_vld || bus.spk_out_rdy);
        acc  = push && ((sz < 16) || pop);
        if (bus.spk_out_vld && bus.spk_out_rdy && rst_n && !clr) hs_log.push_back(bus.spk_out_data);
        @(posedge clk);
        #1;
        if (!rst_n || clr) begin
            m_q.delete();
            m_vld = 1'b0; m_data = '0; m_full = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
            m_cnt = 0; m_phase = 0;
        end else begin
            m_done = 1'b0;
            if (m_phase == 0 && busy) begin
                m_phase = 1; m_cnt = 0;
            end else if (m_phase == 1 && !busy) begin
                m_phase = 2;
            end else if (m_phase == 2 && busy) begin
                m_phase = 1;
            end else if (m_phase == 2 && sz == 0 && !m_vld && !push) begin
                m_phase = 0; m_done = 1'b1;
            end
            if (acc && m_cnt < CMAX) m_cnt++;
            if (pop) begin
                m_data = m_q.pop_front();
                m_vld  = 1'b1;
            end else if (bus.spk_out_rdy) begin
                m_vld = 1'b0;
            end
            if (acc) m_q.push_back(id);
            if (push && !acc) m_ovf = 1'b1;
            m_full = (m_q.size() >= 12);
        end
        if (spk_out_done) done_cnt++;
    endtask

    task automatic fire(input logic [SW-1:0] nid);
        s_vld = 1'b1; s_spk = 1'b1; id = nid;
        tick();
        s_vld = 1'b0; s_spk = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        busy = 1'b0; s_vld = 1'b0; s_spk = 1'b0; bus.spk_out_rdy = 1'b1;
        while ((m_phase != 0 || m_vld || m_q.size() != 0 || m_done) && n < 60) begin
            tick(); n++;
            if (dut_v() !== mdl_v()) begin
                n_fail++; $display("FAIL drain: dut=%h exp=%h", dut_v(), mdl_v());
            end
            n_tests++;
        end
        if (n >= 60) begin
            n_fail++; $display("FAIL drain_timeout: got %0d cycles, need < 60", n);
        end
        n_tests++;
        hs_log.delete(); done_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_vld = 1'b1; s_spk = 1'b1; busy = 1'b1; bus.spk_out_rdy = 1'b0; id = 24'hABCDEF;
        tick(); tick();
        if (dut_v() !== '0) begin
            n_fail++; $display("FAIL reset_outputs: dut=%h exp=0", dut_v());
        end
        n_tests++;
        s_vld = 1'b0; s_spk = 1'b0; busy = 1'b0; rst_n = 1'b1;
        tick();
        if (dut_v() !== mdl_v()) begin
            n_fail++; $display("FAIL reset_idle: dut=%h exp=%h", dut_v(), mdl_v());
        end
        n_tests++;
    endtask

    task automatic test_basic();
        logic [SW-1:0] ids [3] = '{24'h010203, 24'h010204, 24'h010205};
        bus.spk_out_rdy = 1'b1; busy = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            fire(ids[i]);
            if (dut_v() !== mdl_v()) begin
                n_fail++; $display("FAIL basic_fire%0d: dut=%h exp=%h", i, dut_v(), mdl_v());
            end
            n_tests++;
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 3) busy = 1'b0;
            tick();
            if (dut_v() !== mdl_v()) begin
                n_fail++; $display("FAIL basic_cyc%0d: dut=%h exp=%h", i, dut_v(), mdl_v());
            end
            n_tests++;
        end
        if (hs_log.size() != 3 || hs_log[0] !== ids[0] || hs_log[1] !== ids[1] || hs_log[2] !== ids[2]) begin
            n_fail++; $display("FAIL basic_order: got %0d packets, need 3 in order", hs_log.size());
        end
        n_tests++;
        if (spk_cnt !== CW'(3) || done_cnt != 1) begin
            n_fail++; $display("FAIL basic_cnt_done: cnt=%0d done=%0d, need 3 and 1", spk_cnt, done_cnt);
        end
        n_tests++;
        drain();
    endtask

    task automatic test_full_hold();
        logic [SW-1:0] held;
        bus.spk_out_rdy = 1'b0; busy = 1'b1;
        for (int i = 0; i < 13; i++) begin
            fire(SW'($urandom));
            if (i == 1) held = bus.spk_out_data;
            if (dut_v() !== mdl_v()) begin
                n_fail++; $display("FAIL full_fire%0d: dut=%h exp=%h", i, dut_v(), mdl_v());
            end
            n_tests++;
            if (i > 1 && bus.spk_out_data !== held) begin
                n_fail++; $display("FAIL full_hold: data=%h need %h", bus.spk_out_data, held);
            end
            if (i > 1) n_tests++;
        end
        drain();
    endtask

    task automatic test_overflow();
        logic [SW-1:0] exp_ids [$];
        bus.spk_out_rdy = 1'b0; busy = 1'b1;
        for (int i = 0; i < 18; i++) begin
            exp_ids.push_back(SW'($urandom));
            fire(exp_ids[i]);
            if (dut_v() !== mdl_v()) begin
                n_fail++; $display("FAIL ovf_fire%0d: dut=%h exp=%h", i, dut_v(), mdl_v());
            end
            n_tests++;
        end
        bus.spk_out_rdy = 1'b1;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (dut_v() !== mdl_v()) begin
                n_fail++; $display("FAIL ovf_drain%0d: dut=%h exp=%h", i, dut_v(), mdl_v());
            end
            n_tests++;
        end
        if (hs_log.size() != 17 || spk_ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_count: got %0d packets ovf=%b, need 17 and 1", hs_log.size(), spk_ovf);
        end
        n_tests++;
        for (int i = 0; i < 17 && i < hs_log.size(); i++) begin
            if (hs_log[i] !== exp_ids[i]) begin
                n_fail++; $display("FAIL ovf_order%0d: got %h need %h", i, hs_log[i], exp_ids[i]);
            end
            n_tests++;
        end
        clr = 1'b1; tick(); clr = 1'b0;
        drain();
    endtask

    task automatic test_push_pop_full();
        bus.spk_out_rdy = 1'b0; busy = 1'b1;
        for (int i = 0; i < 17; i++) fire(SW'($urandom));
        bus.spk_out_rdy = 1'b1;
        fire(SW'($urandom));
        if (dut_v() !== mdl_v() || spk_ovf !== 1'b0) begin
            n_fail++; $display("FAIL pushpop_full: dut=%h exp=%h ovf=%b", dut_v(), mdl_v(), spk_ovf);
        end
        n_tests++;
        drain();
    endtask

    task automatic test_busy_toggle();
        int fires = 0;
        busy = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c == 20) busy = 1'b0;
            bus.spk_out_rdy = c[0];
            if (c < 20 && fires < 5 && (c >= 15 || $urandom_range(0, 2) == 0)) begin
                fire(SW'($urandom)); fires++;
            end else begin
                tick();
            end
            if (dut_v() !== mdl_v()) begin
                n_fail++; $display("FAIL toggle_cyc%0d: dut=%h exp=%h", c, dut_v(), mdl_v());
            end
            n_tests++;
        end
        if (done_cnt != 1 || hs_log.size() != 5 || spk_cnt !== CW'(5)) begin
            n_fail++; $display("FAIL toggle_summary: done=%0d pkts=%0d cnt=%0d, need 1 5 5", done_cnt, hs_log.size(), spk_cnt);
        end
        n_tests++;
        drain();
    endtask

    task automatic test_clear();
        bus.spk_out_rdy = 1'b0; busy = 1'b1;
        for (int i = 0; i < 9; i++) fire(SW'($urandom));
        s_vld = 1'b1; s_spk = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0; s_vld = 1'b0; s_spk = 1'b0; busy = 1'b0;
        if (dut_v() !== '0) begin
            n_fail++; $display("FAIL clear_outputs: dut=%h exp=0", dut_v());
        end
        n_tests++;
        bus.spk_out_rdy = 1'b1;
        repeat (5) tick();
        if (hs_log.size() != 0 || dut_v() !== mdl_v()) begin
            n_fail++; $display("FAIL clear_stale: pkts=%0d dut=%h exp=%h", hs_log.size(), dut_v(), mdl_v());
        end
        n_tests++;
        drain();
    endtask

    task automatic test_saturate();
        bus.spk_out_rdy = 1'b1; busy = 1'b1;
        for (int i = 0; i < 40; i++) fire(SW'($urandom));
        if (spk_cnt !== CW'(CMAX) || dut_v() !== mdl_v()) begin
            n_fail++; $display("FAIL saturate: cnt=%0d need %0d", spk_cnt, CMAX);
        end
        n_tests++;
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            s_vld = ($urandom_range(0, 3) != 0); s_spk = ($urandom_range(0, 2) != 0);
            id = SW'($urandom);
            bus.spk_out_rdy = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 24) == 0) busy = ~busy;
            clr   = ($urandom_range(0, 149) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
            if (dut_v() !== mdl_v()) begin
                n_fail++; $display("FAIL random_cyc%0d: dut=%h exp=%h", c, dut_v(), mdl_v());
            end
            n_tests++;
        end
        clr = 1'b0; rst_n = 1'b1;
        drain();
    endtask

    initial begin
        bus.spk_out_rdy = 1'b0;
        test_reset();
        test_basic();
        test_full_hold();
        test_overflow();
        test_push_pop_full();
        test_busy_toggle();
        test_clear();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
